skew_reg_bank: RTL and testbench

Parametrised multi-lane delay bank that skews operand vectors into the systolic array. Lane i delays its word by BASE_DELAY + i*STEP enabled cycles, producing the diagonal wavefront the PE grid needs. Every stage carries a valid tag, zero-fills bubbles, and stalls as a unit. An in-flight counter drives `busy`. Sits between the operand buffers and the array edge, replacing chains of discrete per-PE flop registers.

---
 rtl/skew_reg_bank.sv | 121 ++++++++++++
 tb/tb_skew_reg_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/skew_reg_bank.sv
// Multi-lane skew delay bank: lane i delays by BASE_DELAY + i*STEP steps.
// Optional drain FSM (drain_req/drain_done) built when SKEW_DRAIN_EN is defined.
module skew_reg_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int BASE_DELAY = 1,
  parameter int STEP       = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
`ifdef SKEW_DRAIN_EN
  input  logic                        drain_req,
  output logic                        drain_done,
`endif
  output logic [LANES-1:0]            out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        busy
);

  localparam int MAXD = BASE_DELAY + (LANES - 1) * STEP;
  localparam int CW   = $clog2(MAXD + 2);

  logic          adv;
  logic          vin;
  logic          inc;
  logic          dec;
  logic [CW-1:0] cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = BASE_DELAY + i * STEP;

    logic [D-1:0]          v;
    logic [DATA_WIDTH-1:0] d [D];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v <= '0;
        for (int s = 0; s < D; s++) d[s] <= '0;
      end else if (adv) begin
        v[0] <= vin;
        d[0] <= vin ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s < D; s++) begin
          v[s] <= v[s-1];
          d[s] <= d[s-1];
        end
      end
    end

    assign out_valid[i] = v[D-1];
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = d[D-1];
  end

  // The deepest lane is the last to release a vector, so it retires it.
  assign inc  = adv & vin;
  assign dec  = adv & out_valid[LANES-1];
  assign busy = (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + CW'(inc) - CW'(dec);
  end

  cnt_bound: assert property (
    @(posedge clk) disable iff (!reset_n)
    cnt != CW'(MAXD + 1)
  );

`ifdef SKEW_DRAIN_EN
  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (drain_req) begin
            if (cnt == '0) begin
              state      <= DONE;
              drain_done <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          drain_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign adv = en | (state == DRAIN);
  assign vin = in_valid & (state != DRAIN);
`else
  assign adv = en;
  assign vin = in_valid;
`endif

endmodule

// File: tb/tb_skew_reg_bank.sv
// Randomised bench for skew_reg_bank against a history-based lane model.
module tb_skew_reg_bank;

  localparam int DW   = 16;
  localparam int L    = 4;
  localparam int BD   = 1;
  localparam int ST   = 1;
  localparam int MAXD = BD + (L - 1) * ST;
  localparam int W    = L * DW;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [L-1:0] out_valid;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef SKEW_DRAIN_EN
  logic         drain_req;
  logic         drain_done;
`endif

  int errors = 0;
  int checks = 0;
  int advn;
  logic         hv [0:4095];
  logic [W-1:0] hd [0:4095];

  always #5 clk = ~clk;

  skew_reg_bank #(
    .DATA_WIDTH(DW),
    .LANES(L),
    .BASE_DELAY(BD),
    .STEP(ST)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .in_valid(in_valid),
    .in_data(in_data),
`ifdef SKEW_DRAIN_EN
    .drain_req(drain_req),
    .drain_done(drain_done),
`endif
    .out_valid(out_valid),
    .out_data(out_data),
    .busy(busy)
  );

  function automatic int dly(int i);
    return BD + i * ST;
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Vector accepted on adv edge j shows on lane i once advn = j + D(i) - 1,
  // and stays in flight until advn = j + MAXD.
  task automatic model_check();
    logic [L-1:0] ev;
    logic [W-1:0] ed;
    int           n;
    int           j;
    ev = '0;
    ed = '0;
    n  = 0;
    for (int i = 0; i < L; i++) begin
      j = advn - dly(i) + 1;
      if (j >= 1 && hv[j]) begin
        ev[i] = 1'b1;
        ed[i*DW +: DW] = hd[j][i*DW +: DW];
      end
    end
    for (int k = advn - MAXD + 1; k <= advn; k++)
      if (k >= 1 && hv[k]) n++;
    chk("out_valid", W'(out_valid), W'(ev));
    chk("out_data", out_data, ed);
    chk("busy", W'(busy), W'(n != 0));
    chk("cnt", W'(dut.cnt), W'(n));
  endtask

  task automatic cyc(input logic e, input logic v, input logic [W-1:0] d);
    en       = e;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    if (e) begin
      advn++;
      hv[advn] = v;
      hd[advn] = d;
    end
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int peak;
    reset_n  = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    advn     = 0;
`ifdef SKEW_DRAIN_EN
    drain_req = 1'b0;
`endif
    #2;
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_busy", W'(busy), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // skew latency
    cyc(1'b1, 1'b1, 64'h0004_0003_0002_0001);
    chk("skew_v0", W'(out_valid), W'(4'b0001));
    chk("skew_d0", out_data, 64'h0000_0000_0000_0001);
    cyc(1'b1, 1'b0, rnd());
    chk("skew_v1", W'(out_valid), W'(4'b0010));
    chk("skew_d1", out_data, 64'h0000_0000_0002_0000);
    cyc(1'b1, 1'b0, rnd());
    chk("skew_v2", W'(out_valid), W'(4'b0100));
    cyc(1'b1, 1'b0, rnd());
    chk("skew_d3", out_data, 64'h0004_0000_0000_0000);
    cyc(1'b1, 1'b0, rnd());
    chk("skew_idle", W'(busy), '0);

    // stall: pulses during en=0 are ignored
    cyc(1'b1, 1'b1, rnd());
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, rnd());
    chk("stall_cnt", W'(dut.cnt), W'(1));
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, rnd());

    // streaming
    peak = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, {4{16'(16'h0010 + k)}});
      if (int'(dut.cnt) > peak) peak = int'(dut.cnt);
    end
    chk("stream_peak", W'(peak), W'(4));
    for (int t = 1; t <= 4; t++) begin
      cyc(1'b1, 1'b0, rnd());
      chk("stream_busy", W'(busy), W'(t < 4));
    end

    // bubble
    cyc(1'b1, 1'b1, {4{16'h00aa}});
    cyc(1'b1, 1'b0, rnd());
    chk("bubble_v", W'(out_valid[0]), '0);
    chk("bubble_d", W'(out_data[DW-1:0]), '0);
    cyc(1'b1, 1'b1, {4{16'h00bb}});
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, rnd());

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, rnd());
    chk("pre_rst_cnt", W'(dut.cnt), W'(3));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", W'(out_valid), '0);
    chk("arst_data", out_data, '0);
    chk("arst_busy", W'(busy), '0);
    advn = 0;
    #1;
    reset_n = 1'b1;

    // random traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd());
    for (int k = 0; k < MAXD + 1; k++) cyc(1'b1, 1'b0, rnd());

`ifdef SKEW_DRAIN_EN
    begin
      int  pulses;
      logic prev_busy;
      logic seen;
      cyc(1'b1, 1'b1, rnd());
      cyc(1'b1, 1'b1, rnd());
      en        = 1'b0;
      in_valid  = 1'b0;
      drain_req = 1'b1;
      @(posedge clk);
      #1;
      drain_req = 1'b0;
      pulses    = 0;
      seen      = 1'b0;
      prev_busy = 1'b1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (drain_done) begin
          pulses++;
          if (!seen) chk("drain_after_cnt0", W'(prev_busy), '0);
          seen = 1'b1;
        end
        prev_busy = busy;
      end
      chk("drain_pulses", W'(pulses), W'(1));
      chk("drain_empty", W'(busy), '0);
      drain_req = 1'b1;
      @(posedge clk);
      #1;
      drain_req = 1'b0;
      @(negedge clk);
      chk("drain_idle_done", W'(drain_done), W'(1));
      @(negedge clk);
      chk("drain_idle_clr", W'(drain_done), '0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
